// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage core: prioritises stage stall requests and sequences exception/ERET redirects.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic        excp_req_i,
  input  logic [31:0] excp_vector_i,
  input  logic        if_ready_i,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        ex_stall_o,
  output logic        mem_stall_o,
  output logic        if_flush_o,
  output logic        id_flush_o,
  output logic        ex_flush_o,
  output logic        mem_flush_o,
  output logic        redirect_o,
  output logic [31:0] flush_pc_o,
  output logic        excp_ack_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_flush_pc;
  logic [31:0] w_next_flush_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_flush_pc <= RESET_PC;
    end else begin
      r_state    <= w_next_state;
      r_flush_pc <= w_next_flush_pc;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_flush_pc = r_flush_pc;
    if_stall_o      = 1'b0;
    id_stall_o      = 1'b0;
    ex_stall_o      = 1'b0;
    mem_stall_o     = 1'b0;
    if_flush_o      = 1'b0;
    id_flush_o      = 1'b0;
    ex_flush_o      = 1'b0;
    mem_flush_o     = 1'b0;
    redirect_o      = 1'b0;
    excp_ack_o      = 1'b0;
    flush_pc_o      = r_flush_pc;

    case (r_state)
      ST_RUN: begin
        // A busy mem stage cannot commit, so its stall outranks a pending exception.
        if (excp_req_i && !mem_stallreq_i) begin
          if_flush_o      = 1'b1;
          id_flush_o      = 1'b1;
          ex_flush_o      = 1'b1;
          mem_flush_o     = 1'b1;
          redirect_o      = 1'b1;
          excp_ack_o      = 1'b1;
          flush_pc_o      = excp_vector_i;
          w_next_flush_pc = excp_vector_i;
          w_next_state    = if_ready_i ? ST_RUN : ST_REDIRECT;
        end else if (mem_stallreq_i) begin
          if_stall_o  = 1'b1;
          id_stall_o  = 1'b1;
          ex_stall_o  = 1'b1;
          mem_flush_o = 1'b1;
        end else if (ex_stallreq_i) begin
          if_stall_o = 1'b1;
          id_stall_o = 1'b1;
          ex_flush_o = 1'b1;
        end else if (id_stallreq_i) begin
          if_stall_o = 1'b1;
          id_flush_o = 1'b1;
        end
      end
      ST_REDIRECT: begin
        redirect_o = 1'b1;
        if_flush_o = 1'b1;
        if (if_ready_i) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Outputs must be quiet during reset even if requesters are still driving.
    if (!rst_n) begin
      if_stall_o   = 1'b0;
      id_stall_o   = 1'b0;
      ex_stall_o   = 1'b0;
      mem_stall_o  = 1'b0;
      if_flush_o   = 1'b0;
      id_flush_o   = 1'b0;
      ex_flush_o   = 1'b0;
      mem_flush_o  = 1'b0;
      redirect_o   = 1'b0;
      excp_ack_o   = 1'b0;
      flush_pc_o   = RESET_PC;
      w_next_state    = ST_RUN;
      w_next_flush_pc = RESET_PC;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (if_stall_o) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (excp_ack_o) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl, checked against a stage-priority reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idReq = 1'b0;
  logic        exReq = 1'b0;
  logic        memReq = 1'b0;
  logic        excpReq = 1'b0;
  logic [31:0] excpVec = '0;
  logic        ifReady = 1'b0;

  logic        ifStall, idStall, exStall, memStall;
  logic        ifFlush, idFlush, exFlush, memFlush;
  logic        redirect, excpAck;
  logic [31:0] flushPc;
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_stallreq_i  (idReq),
    .ex_stallreq_i  (exReq),
    .mem_stallreq_i (memReq),
    .excp_req_i     (excpReq),
    .excp_vector_i  (excpVec),
    .if_ready_i     (ifReady),
    .if_stall_o     (ifStall),
    .id_stall_o     (idStall),
    .ex_stall_o     (exStall),
    .mem_stall_o    (memStall),
    .if_flush_o     (ifFlush),
    .id_flush_o     (idFlush),
    .ex_flush_o     (exFlush),
    .mem_flush_o    (memFlush),
    .redirect_o     (redirect),
    .flush_pc_o     (flushPc),
    .excp_ack_o     (excpAck)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stallCnt),
    .flush_cnt_o    (flushCnt)
`endif
  );

`ifndef PIPE_CTRL_PERF_EN
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

  always #5 clk = ~clk;

  logic [41:0] obs;
  assign obs = {ifStall, idStall, exStall, memStall, ifFlush, idFlush, exFlush, memFlush,
                redirect, excpAck, flushPc};

  // Reference model: stage 0=if .. 3=mem; a stall raised by stage k holds every
  // stage upstream of k and injects a bubble at k.
  bit          modelRedirect;
  logic [31:0] modelPc;
  bit          nxtRedirect;
  logic [31:0] nxtPc;
  logic [31:0] modelStallCnt, modelFlushCnt;
  logic [41:0] exp;
  logic        expIfStall, expAck;

  task automatic predict();
    logic [3:0]  st, fl;
    logic        rd, ak;
    logic [31:0] pc;
    int          deepest;
    st = '0; fl = '0; rd = 1'b0; ak = 1'b0; pc = modelPc;
    nxtRedirect = modelRedirect;
    nxtPc = modelPc;
    if (!rst_n) begin
      pc = RESET_PC;
    end else if (modelRedirect) begin
      rd = 1'b1;
      fl[0] = 1'b1;
      if (ifReady) nxtRedirect = 1'b0;
    end else if (excpReq && !memReq) begin
      fl = 4'b1111;
      rd = 1'b1;
      ak = 1'b1;
      pc = excpVec;
      nxtPc = excpVec;
      nxtRedirect = !ifReady;
    end else begin
      deepest = memReq ? 3 : exReq ? 2 : idReq ? 1 : 0;
      for (int s = 0; s < deepest; s++) st[s] = 1'b1;
      if (deepest > 0) fl[deepest] = 1'b1;
    end
    expIfStall = st[0];
    expAck = ak;
    exp = {st[0], st[1], st[2], st[3], fl[0], fl[1], fl[2], fl[3], rd, ak, pc};
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic excp, input logic [31:0] vec, input logic rdy);
    idReq = id; exReq = ex; memReq = mem;
    excpReq = excp; excpVec = vec; ifReady = rdy;
    predict();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (expIfStall) modelStallCnt = modelStallCnt + 32'd1;
      if (expAck) modelFlushCnt = modelFlushCnt + 32'd1;
      modelRedirect = nxtRedirect;
      modelPc = nxtPc;
    end
    #1;
  endtask

  task automatic modelReset();
    modelRedirect = 1'b0;
    modelPc = RESET_PC;
    modelStallCnt = '0;
    modelFlushCnt = '0;
  endtask

  task automatic test_reset();
    modelReset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, exp);
    end
    checks++;
    if (flushPc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected %h", flushPc, RESET_PC);
    end
    tick();
  endtask

  task automatic test_id_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL id_stall: got %h expected %h", obs, exp);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL id_stall_after: got %h expected %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_ex_over_id();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (obs !== exp || idFlush !== 1'b0 || exFlush !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ex_over_id[%0d]: got %h expected %h", c, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_excp_ready();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b1);
    checks++;
    if (obs !== exp || flushPc !== 32'hBFC0_0380 || excpAck !== 1'b1) begin
      errors++;
      $display("[TB] FAIL excp_ready: got %h expected %h", obs, exp);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL excp_ready_after: got %h expected %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_excp_wait();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
      else drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_0000, (c == 2));
      checks++;
      if (obs !== exp || (c < 3 && (redirect !== 1'b1 || flushPc !== 32'hBFC0_0380))) begin
        errors++;
        $display("[TB] FAIL excp_wait[%0d]: got %h expected %h", c, obs, exp);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_excp_mem_blocked();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, (c < 2), 1'b1, 32'h8000_0180, 1'b1);
      checks++;
      if (obs !== exp || excpAck !== (c == 2)) begin
        errors++;
        $display("[TB] FAIL excp_mem_blocked[%0d]: got %h expected %h", c, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000 + 32'(c * 16), (c != 0));
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", c, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_redirect();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);
    rst_n = 1'b0;
    modelReset();
    predict();
    #1;
    checks++;
    if (obs !== exp || flushPc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_in_redirect: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp || stallCnt !== 32'd0 || flushCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_redirect_release: got %h/%0d/%0d expected %h/0/0",
               obs, stallCnt, flushCnt, exp);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 6) == 0), $urandom, ($urandom_range(0, 2) != 0));
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %h expected %h", c, obs, exp);
      end
      checks++;
      if (({ifStall, idStall, exStall, memStall} & {ifFlush, idFlush, exFlush, memFlush}) !== 4'b0) begin
        errors++;
        $display("[TB] FAIL stall_flush_overlap[%0d]: got %b%b%b%b/%b%b%b%b expected no overlap",
                 c, ifStall, idStall, exStall, memStall, ifFlush, idFlush, exFlush, memFlush);
      end
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stallCnt !== modelStallCnt || flushCnt !== modelFlushCnt) begin
      errors++;
      $display("[TB] FAIL perf_counters: got %0d/%0d expected %0d/%0d",
               stallCnt, flushCnt, modelStallCnt, modelFlushCnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_ex_over_id();
    test_excp_ready();
    test_excp_wait();
    test_excp_mem_blocked();
    test_back_to_back();
    test_reset_in_redirect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage MIPS core. It replaces the constant-zero stall and flush tie-offs on the pc, decoder, execute and mem stages. It resolves stall requests from decode, execute and mem by priority into per-stage hold and bubble controls. It also sequences exception/ERET redirection, including a wait state until fetch accepts the new PC.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, value of flush_pc_o out of reset.

Ports:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_stallreq_i  in  1  decode stall request (load-use hazard).
- ex_stallreq_i  in  1  execute stall request (multi-cycle mult/div).
- mem_stallreq_i  in  1  mem stall request (data SRAM busy).
- excp_req_i  in  1  mem stage commits an exception or ERET this cycle; level, held by source until accepted.
- excp_vector_i  in  32  target PC (handler entry or EPC), valid with excp_req_i.
- if_ready_i  in  1  fetch accepts redirect this cycle.
- if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold that stage's output register.
- if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  clear that stage's output register at next edge (bubble).
- redirect_o  out  1  fetch must load flush_pc_o.
- flush_pc_o  out  32  redirect target.
- excp_ack_o  out  1  excp_req_i accepted this cycle.

## Operation
- States: RUN, REDIRECT. Reset state RUN.
- RUN, exception accepted when excp_req_i=1 and mem_stallreq_i=0:
  - if/id/ex/mem_flush_o=1 and all stall outputs 0.
  - redirect_o=1, flush_pc_o=excp_vector_i, excp_ack_o=1.
  - excp_vector_i is captured into flush_pc_q.
  - Next state is RUN if if_ready_i=1, else REDIRECT.
- RUN, excp_req_i=1 with mem_stallreq_i=1: the exception is not accepted; the mem stall rule applies and excp_ack_o=0.
- RUN, no exception: only the highest-priority stall request acts.
  - mem_stallreq_i: if/id/ex_stall_o=1, mem_flush_o=1.
  - else ex_stallreq_i: if/id_stall_o=1, ex_flush_o=1.
  - else id_stallreq_i: if_stall_o=1, id_flush_o=1.
  - else all stall and flush outputs 0.
- REDIRECT:
  - redirect_o=1, flush_pc_o=flush_pc_q, if_flush_o=1; all other outputs 0.
  - Stall requests and excp_req_i are ignored (pipeline already empty).
  - Returns to RUN on the cycle if_ready_i=1.
- Invariant: no stage ever has stall_o and flush_o both high in the same cycle.
- flush_pc_o in RUN with no exception = flush_pc_q; redirect_o=0 then.

## Timing
- All stall/flush/redirect outputs are combinational from inputs and state: zero-cycle latency from request to control.
- State and flush_pc_q update on the rising clk edge.
- Exception to fetch redirect: same cycle when if_ready_i=1; otherwise held until the first cycle if_ready_i=1.
- Reset: asynchronous; while rst_n=0 every output is 0 except flush_pc_o=RESET_PC. state=RUN, flush_pc_q=RESET_PC, counters=0.
- Reset asserted in REDIRECT aborts the redirect; no ack is replayed.
- Back-to-back exceptions: a second excp_req_i is accepted on the first RUN cycle after leaving REDIRECT.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle if_stall_o=1.
  - flush_cnt_o increments each accepted exception.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters absent; control behaviour identical.

## Test plan
- id_stallreq_i=1 for 1 cycle -> if_stall_o=1, id_flush_o=1, all other controls 0; next cycle all 0.
- ex_stallreq_i=1 and id_stallreq_i=1 for 3 cycles -> if/id_stall_o=1 and ex_flush_o=1 each cycle, id_flush_o=0.
- excp_req_i=1, excp_vector_i=32'hBFC0_0380, if_ready_i=1 -> all four flushes=1, redirect_o=1, flush_pc_o=32'hBFC0_0380, excp_ack_o=1; next cycle RUN with outputs 0.
- Same exception with if_ready_i=0 for 2 cycles -> redirect_o=1, if_flush_o=1, flush_pc_o=32'hBFC0_0380 for 3 cycles total; if_ready_i=1 on third -> RUN.
- excp_req_i=1 with mem_stallreq_i=1 for 2 cycles, then mem_stallreq_i=0 -> mem stall pattern and excp_ack_o=0 for 2 cycles, then ack and flush on the third cycle.
- rst_n low mid-REDIRECT -> outputs 0 and flush_pc_o=RESET_PC immediately; with PIPE_CTRL_PERF_EN, both counters read 0 after release.
